// File: rtl/bru_pkg.sv
// Shared types and helpers for the branch redirect unit.
package bru_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SHADOW = 2'd2
    } bru_state_t;

    // Lane-index width, never narrower than one bit.
    function automatic int unsigned bru_idx_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/bru_oldest_sel.sv
// Priority selector: lowest-index set bit wins; younger lanes above it are masked.
module bru_oldest_sel
    import bru_pkg::*;
#(
    parameter int unsigned LANES = 2
) (
    input  logic [LANES-1:0]              mis,
    output logic [bru_idx_w(LANES)-1:0]   sel_idx_c,
    output logic                          found_c,
    output logic [LANES-1:0]              younger_c
);

    localparam int unsigned IDX_W = bru_idx_w(LANES);

    // Scan oldest to youngest; every lane after the first hit is younger.
    always_comb begin
        found_c   = 1'b0;
        sel_idx_c = '0;
        younger_c = '0;
        for (int i = 0; i < LANES; i++) begin
            younger_c[i] = found_c;
            if (mis[i] && !found_c) begin
                found_c   = 1'b1;
                sel_idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Branch resolution and fetch redirect with a post-redirect shadow window.
// Optional statistics counters are enabled by defining BRU_STATS_EN.
module branch_redirect_unit
    import bru_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned PC_W   = 8,
    parameter int unsigned SHADOW = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LANES-1:0]              lane_valid,
    input  logic [LANES-1:0]              lane_is_branch,
    input  logic [LANES-1:0]              lane_pred_taken,
    input  logic [LANES-1:0]              lane_taken,
    input  logic [LANES*PC_W-1:0]         lane_pc,
    input  logic [LANES*PC_W-1:0]         lane_pred_target,
    input  logic [LANES*PC_W-1:0]         lane_target,
    input  logic                          redirect_ready,
    output logic                          redirect_valid,
    output logic [PC_W-1:0]               redirect_pc,
    output logic [bru_idx_w(LANES)-1:0]   redirect_lane,
    output logic [LANES-1:0]              flush_mask,
    output logic                          busy
`ifdef BRU_STATS_EN
    ,
    output logic [CNT_W-1:0]              stat_branches,
    output logic [CNT_W-1:0]              stat_mispredicts
`endif
);

    localparam int unsigned IDX_W = bru_idx_w(LANES);
    localparam int unsigned SH_W  = (SHADOW > 1) ? $clog2(SHADOW) : 1;

    bru_state_t              state_q, state_nxt;
    logic [SH_W-1:0]         shadow_cnt_q, shadow_cnt_nxt;
    logic                    redirect_valid_nxt;
    logic [PC_W-1:0]         redirect_pc_nxt;
    logic [IDX_W-1:0]        redirect_lane_nxt;
    logic [LANES-1:0]        flush_mask_nxt;
    logic                    busy_nxt;
    logic                    capture_c;

    logic [LANES-1:0]        mis_c;
    logic [IDX_W-1:0]        sel_idx_c;
    logic                    found_c;
    logic [LANES-1:0]        younger_c;
    logic                    win_taken_c;
    logic [PC_W-1:0]         win_pc_c;
    logic [PC_W-1:0]         win_target_c;

    // Per-lane mispredict detection; only honoured while IDLE.
    always_comb begin
        mis_c = '0;
        for (int i = 0; i < LANES; i++) begin
            mis_c[i] = (state_q == bru_pkg::IDLE) && lane_valid[i] && lane_is_branch[i] &&
                       ((lane_taken[i] != lane_pred_taken[i]) ||
                        (lane_taken[i] &&
                         (lane_pred_target[i*PC_W +: PC_W] != lane_target[i*PC_W +: PC_W])));
        end
    end

    bru_oldest_sel #(
        .LANES (LANES)
    ) u_oldest_sel (
        .mis       (mis_c),
        .sel_idx_c (sel_idx_c),
        .found_c   (found_c),
        .younger_c (younger_c)
    );

    // Mux out the winning lane's resolution fields.
    always_comb begin
        win_taken_c  = 1'b0;
        win_pc_c     = '0;
        win_target_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (IDX_W'(i) == sel_idx_c) begin
                win_taken_c  = lane_taken[i];
                win_pc_c     = lane_pc[i*PC_W +: PC_W];
                win_target_c = lane_target[i*PC_W +: PC_W];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt         = state_q;
        shadow_cnt_nxt    = shadow_cnt_q;
        redirect_pc_nxt   = redirect_pc;
        redirect_lane_nxt = redirect_lane;
        flush_mask_nxt    = '0;
        capture_c         = 1'b0;

        case (state_q)
            bru_pkg::IDLE: begin
                if (found_c) begin
                    capture_c         = 1'b1;
                    redirect_pc_nxt   = win_taken_c ? win_target_c : PC_W'(win_pc_c + PC_W'(1));
                    redirect_lane_nxt = sel_idx_c;
                    flush_mask_nxt    = younger_c;
                    state_nxt         = bru_pkg::HOLD;
                end
            end
            bru_pkg::HOLD: begin
                if (redirect_ready) begin
                    if (SHADOW != 0) begin
                        state_nxt      = bru_pkg::SHADOW;
                        shadow_cnt_nxt = SH_W'(SHADOW - 1);
                    end else begin
                        state_nxt = bru_pkg::IDLE;
                    end
                end
            end
            bru_pkg::SHADOW: begin
                if (shadow_cnt_q == '0) begin
                    state_nxt = bru_pkg::IDLE;
                end else begin
                    shadow_cnt_nxt = shadow_cnt_q - SH_W'(1);
                end
            end
            default: state_nxt = bru_pkg::IDLE;
        endcase

        redirect_valid_nxt = (state_nxt == bru_pkg::HOLD);
        busy_nxt           = (state_nxt != bru_pkg::IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= bru_pkg::IDLE;
            shadow_cnt_q   <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            redirect_lane  <= '0;
            flush_mask     <= '0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            shadow_cnt_q   <= shadow_cnt_nxt;
            redirect_valid <= redirect_valid_nxt;
            redirect_pc    <= redirect_pc_nxt;
            redirect_lane  <= redirect_lane_nxt;
            flush_mask     <= flush_mask_nxt;
            busy           <= busy_nxt;
        end
    end

`ifdef BRU_STATS_EN
    localparam int unsigned PCW   = $clog2(LANES + 1);
    localparam int unsigned SUM_W = CNT_W + PCW;

    logic [PCW-1:0]   br_cnt_c;
    logic [SUM_W-1:0] br_sum_c;
    logic [CNT_W-1:0] stat_branches_nxt;
    logic [CNT_W-1:0] stat_mispredicts_nxt;

    // Saturating counters; branches only count while lane inputs are honoured.
    always_comb begin
        br_cnt_c = '0;
        for (int i = 0; i < LANES; i++) begin
            br_cnt_c = br_cnt_c + PCW'(lane_valid[i] & lane_is_branch[i]);
        end
        br_sum_c             = SUM_W'(stat_branches) + SUM_W'(br_cnt_c);
        stat_branches_nxt    = stat_branches;
        stat_mispredicts_nxt = stat_mispredicts;
        if (state_q == bru_pkg::IDLE) begin
            stat_branches_nxt = (br_sum_c > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                                   : CNT_W'(br_sum_c);
        end
        if (capture_c && (stat_mispredicts != {CNT_W{1'b1}})) begin
            stat_mispredicts_nxt = stat_mispredicts + CNT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_branches    <= stat_branches_nxt;
            stat_mispredicts <= stat_mispredicts_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit: directed cases plus randomized traffic.
module tb_branch_redirect_unit;

    localparam int unsigned LANES  = 2;
    localparam int unsigned PC_W   = 8;
    localparam int unsigned SHADOW = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int          PC_MOD = 1 << PC_W;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   rst_n;
    logic [LANES-1:0]       lane_valid;
    logic [LANES-1:0]       lane_is_branch;
    logic [LANES-1:0]       lane_pred_taken;
    logic [LANES-1:0]       lane_taken;
    logic [LANES*PC_W-1:0]  lane_pc;
    logic [LANES*PC_W-1:0]  lane_pred_target;
    logic [LANES*PC_W-1:0]  lane_target;
    logic                   redirect_ready;
    logic                   redirect_valid;
    logic [PC_W-1:0]        redirect_pc;
    logic [0:0]             redirect_lane;
    logic [LANES-1:0]       flush_mask;
    logic                   busy;
`ifdef BRU_STATS_EN
    logic [CNT_W-1:0]       stat_branches;
    logic [CNT_W-1:0]       stat_mispredicts;
`endif

    branch_redirect_unit #(
        .LANES  (LANES),
        .PC_W   (PC_W),
        .SHADOW (SHADOW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lane_valid       (lane_valid),
        .lane_is_branch   (lane_is_branch),
        .lane_pred_taken  (lane_pred_taken),
        .lane_taken       (lane_taken),
        .lane_pc          (lane_pc),
        .lane_pred_target (lane_pred_target),
        .lane_target      (lane_target),
        .redirect_ready   (redirect_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_lane    (redirect_lane),
        .flush_mask       (flush_mask),
        .busy             (busy)
`ifdef BRU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus held per lane as plain integers.
    int lv [LANES];
    int lb [LANES];
    int lpt[LANES];
    int lt [LANES];
    int lpc[LANES];
    int lpg[LANES];
    int ltg[LANES];

    // Reference model: pending redirect, remaining ignore cycles, last capture.
    int m_pending;
    int m_ignore;
    int m_pc;
    int m_lane;
    int m_flush;
    int m_br;
    int m_mis;

    int checks;
    int failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < LANES; i++) begin
            lane_valid[i]                    = (lv[i] != 0);
            lane_is_branch[i]                = (lb[i] != 0);
            lane_pred_taken[i]               = (lpt[i] != 0);
            lane_taken[i]                    = (lt[i] != 0);
            lane_pc[i*PC_W +: PC_W]          = PC_W'(lpc[i]);
            lane_pred_target[i*PC_W +: PC_W] = PC_W'(lpg[i]);
            lane_target[i*PC_W +: PC_W]      = PC_W'(ltg[i]);
        end
    endtask

    task automatic set_lane(input int i, input int v, input int b, input int pt, input int t,
                            input int pc, input int pg, input int tg);
        lv[i] = v; lb[i] = b; lpt[i] = pt; lt[i] = t;
        lpc[i] = pc; lpg[i] = pg; ltg[i] = tg;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < LANES; i++) set_lane(i, 0, 0, 0, 0, 0, 0, 0);
        drive();
    endtask

    task automatic model_clear();
        m_pending = 0; m_ignore = 0; m_pc = 0; m_lane = 0; m_flush = 0; m_br = 0; m_mis = 0;
    endtask

    function automatic int lane_wrong(input int i);
        if (lv[i] == 0 || lb[i] == 0) return 0;
        if (lt[i] != lpt[i]) return 1;
        if (lt[i] != 0 && lpg[i] != ltg[i]) return 1;
        return 0;
    endfunction

    // Advance the model by one cycle using the currently driven inputs.
    task automatic model_step();
        int win;
        int nbr;
        m_flush = 0;
        if (m_pending != 0) begin
            if (redirect_ready) begin
                m_pending = 0;
                m_ignore  = SHADOW;
            end
        end else if (m_ignore > 0) begin
            m_ignore--;
        end else begin
            nbr = 0;
            win = -1;
            for (int i = 0; i < LANES; i++) begin
                if (lv[i] != 0 && lb[i] != 0) nbr++;
                if (win < 0 && lane_wrong(i) != 0) win = i;
            end
            m_br = (m_br + nbr > CNT_MAX) ? CNT_MAX : m_br + nbr;
            if (win >= 0) begin
                m_pending = 1;
                m_lane    = win;
                m_pc      = (lt[win] != 0) ? ltg[win] : (lpc[win] + 1) % PC_MOD;
                m_flush   = ((1 << LANES) - 1) & ~((1 << (win + 1)) - 1);
                if (m_mis < CNT_MAX) m_mis++;
            end
        end
    endtask

    task automatic check_all();
        chk("redirect_valid", 32'(redirect_valid), 32'(m_pending));
        chk("redirect_pc",    32'(redirect_pc),    32'(m_pc));
        chk("redirect_lane",  32'(redirect_lane),  32'(m_lane));
        chk("flush_mask",     32'(flush_mask),     32'(m_flush));
        chk("busy",           32'(busy),           32'((m_pending != 0) || (m_ignore > 0)));
`ifdef BRU_STATS_EN
        chk("stat_branches",    32'(stat_branches),    32'(m_br));
        chk("stat_mispredicts", 32'(stat_mispredicts), 32'(m_mis));
`endif
    endtask

    task automatic tick();
        drive();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
    endtask

    task automatic idle_ticks(input int n);
        clear_lanes();
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < LANES; i++) begin
            lv[i]  = ($urandom_range(3) != 0) ? 1 : 0;
            lb[i]  = ($urandom_range(2) != 0) ? 1 : 0;
            lpt[i] = int'($urandom_range(1));
            lt[i]  = int'($urandom_range(1));
            lpc[i] = int'($urandom_range(PC_MOD - 1));
            lpg[i] = int'($urandom_range(PC_MOD - 1));
            ltg[i] = ($urandom_range(1) != 0) ? lpg[i] : int'($urandom_range(PC_MOD - 1));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        redirect_ready = 1'b0;
        clear_lanes();
        model_clear();
        rst_n = 1'b0;
        #12;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();

        // Lane 0 direction mispredict, ready already high.
        redirect_ready = 1'b1;
        set_lane(0, 1, 1, 0, 1, 'h10, 'h00, 'h40);
        tick();
        chk("t1_valid", 32'(redirect_valid), 32'd1);
        chk("t1_pc",    32'(redirect_pc),    32'h40);
        chk("t1_lane",  32'(redirect_lane),  32'd0);
        chk("t1_flush", 32'(flush_mask),     32'b10);
        clear_lanes();
        tick();
        chk("t1_valid_drop", 32'(redirect_valid), 32'd0);
        chk("t1_busy",       32'(busy),           32'd1);
        idle_ticks(2);

        // Lane 1 predicted taken, resolved not taken.
        set_lane(0, 1, 1, 0, 0, 'h08, 'h00, 'h00);
        set_lane(1, 1, 1, 1, 0, 'h20, 'h30, 'h30);
        tick();
        chk("t2_pc",    32'(redirect_pc),   32'h21);
        chk("t2_lane",  32'(redirect_lane), 32'd1);
        chk("t2_flush", 32'(flush_mask),    32'd0);
        idle_ticks(3);

        // Fall-through PC wraps to zero.
        set_lane(0, 1, 1, 0, 0, 'h08, 'h00, 'h00);
        set_lane(1, 1, 1, 1, 0, 'hFF, 'h30, 'h30);
        tick();
        chk("t3_wrap_pc", 32'(redirect_pc), 32'h00);
        idle_ticks(3);

        // Backpressure: ready low for 5 cycles while more mispredicts arrive.
        redirect_ready = 1'b0;
        set_lane(0, 1, 1, 1, 1, 'h50, 'h60, 'h66);
        set_lane(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t4_pc", 32'(redirect_pc), 32'h66);
        for (int k = 0; k < 5; k++) begin
            set_lane(0, 1, 1, 0, 1, 'h11 + k, 0, 'h90 + k);
            set_lane(1, 1, 1, 1, 0, 'h22, 'h33, 'h33);
            tick();
            chk("t4_hold_valid", 32'(redirect_valid), 32'd1);
            chk("t4_hold_pc",    32'(redirect_pc),    32'h66);
            chk("t4_hold_flush", 32'(flush_mask),     32'd0);
        end
        redirect_ready = 1'b1;
        tick();
        chk("t4_xfer_valid", 32'(redirect_valid), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t4_shadow_valid", 32'(redirect_valid), 32'd0);
            chk("t4_shadow_flush", 32'(flush_mask),     32'd0);
        end
        tick();
        chk("t4_reaccept", 32'(redirect_valid), 32'd1);
        idle_ticks(4);

        // Asynchronous reset while holding a redirect.
        redirect_ready = 1'b0;
        set_lane(0, 1, 1, 0, 1, 'h70, 0, 'h7A);
        set_lane(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t5_hold", 32'(redirect_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("t5_rst_valid", 32'(redirect_valid), 32'd0);
        chk("t5_rst_pc",    32'(redirect_pc),    32'd0);
        chk("t5_rst_flush", 32'(flush_mask),     32'd0);
        chk("t5_rst_busy",  32'(busy),           32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        redirect_ready = 1'b1;
        set_lane(0, 1, 1, 0, 1, 'h70, 0, 'h5C);
        tick();
        chk("t5_post_valid", 32'(redirect_valid), 32'd1);
        chk("t5_post_pc",    32'(redirect_pc),    32'h5C);

        // Both lanes mispredict the target: oldest wins, single redirect.
        do_reset();
        set_lane(0, 1, 1, 1, 1, 'h01, 'h30, 'h34);
        set_lane(1, 1, 1, 1, 1, 'h02, 'h30, 'h34);
        tick();
        chk("t6_pc",    32'(redirect_pc),   32'h34);
        chk("t6_lane",  32'(redirect_lane), 32'd0);
        chk("t6_flush", 32'(flush_mask),    32'b10);
`ifdef BRU_STATS_EN
        chk("t6_stat_mis", 32'(stat_mispredicts), 32'd1);
`endif
        idle_ticks(4);

        // Correct branches on both lanes for 20 cycles.
        do_reset();
        set_lane(0, 1, 1, 0, 0, 'h10, 0, 0);
        set_lane(1, 1, 1, 1, 1, 'h11, 'h44, 'h44);
        for (int k = 0; k < 20; k++) tick();
        chk("t7_no_redirect", 32'(redirect_valid), 32'd0);
`ifdef BRU_STATS_EN
        chk("t7_stat_sat", 32'(stat_branches), 32'd15);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rand_lanes();
            redirect_ready = ($urandom_range(2) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
